// File: rtl/matrix_result_tx_pkg.sv
// Shared constants, state encoding and element-select helper for the
// matrix result serialiser.
package matrix_result_tx_pkg;

  localparam int N_ELEM    = 9;
  localparam int ELEM_W    = 6;
  localparam int RESULT_W  = N_ELEM * ELEM_W;
  localparam int FRAME_LEN = N_ELEM + 2;

  localparam logic [7:0] HEADER = 8'hA5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_CSUM = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HDR  = ST_HDR,
    DATA = ST_DATA,
    CSUM = ST_CSUM
  } state_e;

  // Zero-extended element idx of the packed result; out-of-range idx yields 0.
  function automatic logic [7:0] elemByte(input logic [RESULT_W-1:0] vec,
                                          input logic [3:0] idx);
    logic [7:0] byteOut;
    byteOut = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      if (int'(idx) == k) begin
        byteOut[ELEM_W-1:0] = vec[k*ELEM_W +: ELEM_W];
      end
    end
    return byteOut;
  endfunction

endpackage

// File: rtl/matrix_result_tx_if.sv
// Bundle of the result input, byte handshake and status lines of the
// matrix result serialiser.
interface matrix_result_tx_if;
  import matrix_result_tx_pkg::*;

  logic [RESULT_W-1:0] result;
  logic                result_valid;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                busy;
  logic                frame_done;
  logic                overrun;

  modport master (
    input  result, result_valid, tx_ready,
    output tx_data, tx_valid, busy, frame_done, overrun
  );

  modport slave (
    output result, result_valid, tx_ready,
    input  tx_data, tx_valid, busy, frame_done, overrun
  );

endinterface

// File: rtl/matrix_result_tx.sv
// Captures a 3x3 product and streams it as header, nine element bytes and
// an 8-bit checksum over a valid/ready byte handshake.
module matrix_result_tx
  import matrix_result_tx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  matrix_result_tx_if.master bus
);

  state_e              state_q;
  logic [RESULT_W-1:0] shadow_q;
  logic [3:0]          index_q;
  logic [7:0]          csum_q;
  logic [7:0]          txData_q;
  logic                txValid_q;
  logic                busy_q;
  logic                frameDone_q;
  logic                overrun_q;

  logic                transfer;
  logic [7:0]          csum_d;
  logic [7:0]          nextData_d;

  assign transfer = txValid_q & bus.tx_ready;

  // After the last element the checksum, including that element, is next.
  always_comb begin
    csum_d     = csum_q + txData_q;
    nextData_d = (index_q == 4'(N_ELEM - 1)) ? csum_d
                                             : elemByte(shadow_q, index_q + 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      index_q     <= '0;
      csum_q      <= '0;
      txData_q    <= '0;
      txValid_q   <= 1'b0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      if (bus.result_valid && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (bus.result_valid) begin
            shadow_q  <= bus.result;
            csum_q    <= '0;
            index_q   <= '0;
            txData_q  <= HEADER;
            txValid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= HDR;
          end
        end

        HDR: begin
          if (transfer) begin
            txData_q <= elemByte(shadow_q, 4'd0);
            state_q  <= DATA;
          end
        end

        DATA: begin
          if (transfer) begin
            csum_q   <= csum_d;
            index_q  <= index_q + 4'd1;
            txData_q <= nextData_d;
            if (index_q == 4'(N_ELEM - 1)) begin
              state_q <= CSUM;
            end
          end
        end

        CSUM: begin
          if (transfer) begin
            txValid_q   <= 1'b0;
            txData_q    <= '0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data    = txData_q;
  assign bus.tx_valid   = txValid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frameDone_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_matrix_result_tx.sv
// Scoreboard bench for matrix_result_tx: expected frames are queued when a
// result is driven and popped as bytes transfer.
module tb_matrix_result_tx;
  import matrix_result_tx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  matrix_result_tx_if bus();

  matrix_result_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         errors    = 0;
  int         doneCount = 0;
  logic [7:0] expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Element k = (base + step*k) mod 64; accepted results queue the full frame.
  task automatic applyStimulus(input int base, input int step, input bit accept);
    logic [RESULT_W-1:0] vec;
    logic [7:0]          sum;
    logic [5:0]          e;
    vec = '0;
    sum = '0;
    if (accept) expQ.push_back(8'hA5);
    for (int k = 0; k < N_ELEM; k++) begin
      e = 6'((base + step * k) & 63);
      vec[k*ELEM_W +: ELEM_W] = e;
      sum = sum + {2'b00, e};
      if (accept) expQ.push_back({2'b00, e});
    end
    if (accept) expQ.push_back(sum);
    bus.result       = vec;
    bus.result_valid = 1'b1;
  endtask

  // Called just after a falling edge: sample outputs, set tx_ready, advance.
  task automatic tickCycle(input logic rdy);
    bus.tx_ready = rdy;
    if (bus.frame_done) doneCount++;
    if (bus.tx_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousValid", 32'(bus.tx_valid), 32'd0);
      end else begin
        checkOutput("txData", 32'(bus.tx_data), 32'(expQ[0]));
        if (rdy) void'(expQ.pop_front());
      end
    end
    @(negedge clk);
    bus.result_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle, input string tag);
    int   budget;
    logic rdy;
    budget = 80;
    rdy    = 1'b1;
    while ((expQ.size() != 0) && (budget > 0)) begin
      tickCycle(rdy);
      if (toggle) rdy = ~rdy;
      budget--;
    end
    checkOutput(tag, 32'(expQ.size()), 32'd0);
    tickCycle(1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    bus.result       = '0;
    bus.result_valid = 1'b0;
    bus.tx_ready     = 1'b0;
    rst              = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (10) begin
      checkOutput("idleValid",   32'(bus.tx_valid), 32'd0);
      checkOutput("idleBusy",    32'(bus.busy),     32'd0);
      checkOutput("idleOverrun", 32'(bus.overrun),  32'd0);
      checkOutput("idleData",    32'(bus.tx_data),  32'd0);
      tickCycle(1'b0);
    end

    // Frame 1: bytes 01..09, checksum 2D, back-to-back
    applyStimulus(1, 1, 1'b1);
    checkOutput("f1Csum", 32'(expQ[10]), 32'h2D);
    tickCycle(1'b1);
    checkOutput("f1BusyHdr",  32'(bus.busy),     32'd1);
    checkOutput("f1ValidHdr", 32'(bus.tx_valid), 32'd1);
    repeat (11) tickCycle(1'b1);
    checkOutput("f1Len", 32'(expQ.size()), 32'd0);
    checkOutput("f1DonePulse", 32'(bus.frame_done), 32'd1);
    tickCycle(1'b1);
    checkOutput("f1DoneCount", 32'(doneCount), 32'd1);
    checkOutput("f1BusyEnd",   32'(bus.busy),  32'd0);
    checkOutput("f1DoneLow",   32'(bus.frame_done), 32'd0);

    // Frame 2: all 3F with tx_ready toggling, checksum 37
    applyStimulus(63, 0, 1'b1);
    checkOutput("f2Csum", 32'(expQ[10]), 32'h37);
    tickCycle(1'b0);
    drain(1'b1, "f2Len");
    checkOutput("f2DoneCount", 32'(doneCount), 32'd2);

    // Frame 3: second result during data byte 4 is dropped
    applyStimulus(10, 1, 1'b1);
    tickCycle(1'b1);
    repeat (5) tickCycle(1'b1);
    applyStimulus(40, 3, 1'b0);
    tickCycle(1'b1);
    checkOutput("overrunSet", 32'(bus.overrun), 32'd1);
    drain(1'b0, "f3Len");
    checkOutput("f3DoneCount", 32'(doneCount), 32'd3);
    repeat (3) begin
      checkOutput("overrunSticky", 32'(bus.overrun),  32'd1);
      checkOutput("noSecondFrame", 32'(bus.tx_valid), 32'd0);
      tickCycle(1'b1);
    end

    // Frame 4: reset while index 5 is presented
    applyStimulus(20, 1, 1'b1);
    tickCycle(1'b1);
    repeat (6) tickCycle(1'b1);
    checkOutput("rstIdx5Data", 32'(bus.tx_data), 32'd25);
    rst = 1'b1;
    tickCycle(1'b0);
    rst = 1'b0;
    expQ.delete();
    checkOutput("rstValid",   32'(bus.tx_valid), 32'd0);
    checkOutput("rstBusy",    32'(bus.busy),     32'd0);
    checkOutput("rstOverrun", 32'(bus.overrun),  32'd0);
    checkOutput("rstData",    32'(bus.tx_data),  32'd0);
    tickCycle(1'b1);
    checkOutput("rstNoResume", 32'(bus.tx_valid), 32'd0);
    applyStimulus(0, 0, 1'b1);
    checkOutput("zeroCsum", 32'(expQ[10]), 32'h00);
    tickCycle(1'b1);
    drain(1'b0, "zeroLen");
    checkOutput("zeroDoneCount", 32'(doneCount), 32'd4);

    // Frames 5/6: new result in the cycle frame_done is high
    applyStimulus(5, 2, 1'b1);
    tickCycle(1'b1);
    budget = 40;
    while ((expQ.size() != 0) && (budget > 0)) begin
      tickCycle(1'b1);
      budget--;
    end
    checkOutput("f5Len", 32'(expQ.size()), 32'd0);
    checkOutput("f5Done", 32'(bus.frame_done), 32'd1);
    applyStimulus(7, 5, 1'b1);
    tickCycle(1'b1);
    checkOutput("b2bValid",   32'(bus.tx_valid), 32'd1);
    checkOutput("b2bHeader",  32'(bus.tx_data),  32'hA5);
    checkOutput("b2bOverrun", 32'(bus.overrun),  32'd0);
    drain(1'b0, "f6Len");
    checkOutput("f6DoneCount", 32'(doneCount), 32'd6);
    checkOutput("f6Overrun",   32'(bus.overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
